// File: rtl/sync_fifo_flags.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo_flags
//  Description : Parametrised single-clock FIFO with occupancy count,
//                programmable almost-full/almost-empty thresholds and sticky
//                overflow/underflow error flags cleared by clr_err.
//  Revision    : 1.0  initial release
// ============================================================================
module sync_fifo_flags #(
   parameter int DATA_W   = 8,
   parameter int DEPTH    = 16,
   parameter int AF_LEVEL = DEPTH - 2,
   parameter int AE_LEVEL = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [DATA_W-1:0]      data_in,
   input  logic                   we,
   input  logic                   re,
   input  logic                   clr_err,
   output logic [DATA_W-1:0]      data_out,
   output logic                   full,
   output logic                   empty,
   output logic                   almost_full,
   output logic                   almost_empty,
   output logic [$clog2(DEPTH):0] count,
   output logic                   overflow,
   output logic                   underflow
);

   localparam int          AW          = $clog2(DEPTH);
   localparam logic [AW:0] c_DEPTH     = (AW+1)'(DEPTH);
   localparam logic [AW:0] c_AF_LEVEL  = (AW+1)'(AF_LEVEL);
   localparam logic [AW:0] c_AE_LEVEL  = (AW+1)'(AE_LEVEL);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [AW:0]       r_count;
   logic [DATA_W-1:0] r_data_out;
   logic              r_overflow;
   logic              r_underflow;

   logic              w_full;
   logic              w_empty;
   logic              w_wr_ok;
   logic              w_rd_ok;

   // Flags are pure decodes of the registered count, so they move with it.
   assign w_full  = (r_count == c_DEPTH);
   assign w_empty = (r_count == '0);

   // When full a simultaneous read still drains, when empty a simultaneous
   // write still fills; the other side of the pair is rejected.
   assign w_wr_ok = we & ~w_full;
   assign w_rd_ok = re & ~w_empty;

   // Storage array: no reset, only written on an accepted write.
   always_ff @(posedge clk) begin
      if (w_wr_ok) begin
         r_mem[r_wr_ptr] <= data_in;
      end
   end

   // Pointers wrap naturally at DEPTH (power of two).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_wr_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_rd_ok) r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // Registered read data; holds when no read is accepted (no fall-through).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_data_out <= '0;
      end else if (w_rd_ok) begin
         r_data_out <= r_mem[r_rd_ptr];
      end
   end

   // Occupancy: net change of accepted write minus accepted read.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
      end else begin
         case ({w_wr_ok, w_rd_ok})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Sticky error flags; a new error event in the same cycle beats clr_err.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (we & w_full)       r_overflow <= 1'b1;
         else if (clr_err)      r_overflow <= 1'b0;
         if (re & w_empty)      r_underflow <= 1'b1;
         else if (clr_err)      r_underflow <= 1'b0;
      end
   end

   assign data_out     = r_data_out;
   assign full         = w_full;
   assign empty        = w_empty;
   assign almost_full  = (r_count >= c_AF_LEVEL);
   assign almost_empty = (r_count <= c_AE_LEVEL);
   assign count        = r_count;
   assign overflow     = r_overflow;
   assign underflow    = r_underflow;

endmodule
`default_nettype wire
